// File: rtl/button_conditioner.sv
// button_conditioner: per-channel synchroniser, debouncer, edge-pulse generator
// and optional auto-repeat for raw push-button inputs. Every channel is fully
// independent. any_level is the OR of all debounced levels, registered with them.
module button_conditioner #(
  parameter int                 N_BTN           = 5,
  parameter int                 DEBOUNCE_CYCLES = 250000,
  parameter int                 REPEAT_DELAY    = 25000000,
  parameter int                 REPEAT_PERIOD   = 5000000,
  parameter logic [N_BTN-1:0]   REPEAT_MASK     = '0
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release,
  output logic [N_BTN-1:0] btn_event,
  output logic             any_level
);

  // Counter widths; a one-cycle debounce or repeat still needs a 1-bit counter.
  localparam int DCNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int RMAX   = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RCNT_W = (RMAX > 1) ? $clog2(RMAX) : 1;

  localparam logic [DCNT_W-1:0] DCNT_LAST    = DCNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [RCNT_W-1:0] RDELAY_LOAD  = RCNT_W'(REPEAT_DELAY - 1);
  localparam logic [RCNT_W-1:0] RPERIOD_LOAD = RCNT_W'(REPEAT_PERIOD - 1);

  typedef enum logic [1:0] {
    R_IDLE   = 2'd0,
    R_DELAY  = 2'd1,
    R_REPEAT = 2'd2
  } rep_state_t;

  // Next-cycle debounced levels, gathered so any_level can be registered with them.
  logic [N_BTN-1:0] level_nxt_v;

  genvar i;
  generate
    for (i = 0; i < N_BTN; i++) begin : g_ch
      logic              s1_p0;
      logic              s2_p1;
      logic              level_p2;
      logic [DCNT_W-1:0] dcnt_p2;
      logic              press_p2;
      logic              rel_p2;
      logic              evt_p2;
      rep_state_t        state_q;
      rep_state_t        state_d;
      logic [RCNT_W-1:0] rcnt_q;
      logic [RCNT_W-1:0] rcnt_d;
      logic              level_d;
      logic [DCNT_W-1:0] dcnt_d;
      logic              press_d;
      logic              rel_d;
      logic              rep_d;

      // Two-flop synchroniser for the asynchronous raw level.
      always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
          s1_p0 <= 1'b0;
          s2_p1 <= 1'b0;
        end else begin
          s1_p0 <= btn_raw[i];
          s2_p1 <= s1_p0;
        end
      end

      // Debounce: count consecutive disagreeing cycles; any agreement restarts the count.
      always_comb begin
        level_d = level_p2;
        dcnt_d  = '0;
        press_d = 1'b0;
        rel_d   = 1'b0;
        if (s2_p1 != level_p2) begin
          if (dcnt_p2 == DCNT_LAST) begin
            level_d = ~level_p2;
            press_d = s2_p1;
            rel_d   = ~s2_p1;
          end else begin
            dcnt_d = dcnt_p2 + DCNT_W'(1);
          end
        end
      end

      // Level, debounce count and registered pulses; pulses appear with the level change.
      always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
          level_p2 <= 1'b0;
          dcnt_p2  <= '0;
          press_p2 <= 1'b0;
          rel_p2   <= 1'b0;
          evt_p2   <= 1'b0;
        end else begin
          level_p2 <= level_d;
          dcnt_p2  <= dcnt_d;
          press_p2 <= press_d;
          rel_p2   <= rel_d;
          evt_p2   <= press_d | rep_d;
        end
      end

      // Repeat FSM next state: the delay is loaded on the same edge that raises the
      // press pulse, so the first repeat lands exactly REPEAT_DELAY edges later.
      // A release takes priority over a repeat falling due on the same edge.
      always_comb begin
        state_d = state_q;
        rcnt_d  = rcnt_q;
        rep_d   = 1'b0;
        if (!REPEAT_MASK[i]) begin
          state_d = R_IDLE;
          rcnt_d  = '0;
        end else if (rel_d) begin
          state_d = R_IDLE;
          rcnt_d  = '0;
        end else begin
          case (state_q)
            R_IDLE: begin
              if (press_d) begin
                state_d = R_DELAY;
                rcnt_d  = RDELAY_LOAD;
              end
            end
            R_DELAY, R_REPEAT: begin
              if (level_p2) begin
                if (rcnt_q == '0) begin
                  rep_d   = 1'b1;
                  rcnt_d  = RPERIOD_LOAD;
                  state_d = R_REPEAT;
                end else begin
                  rcnt_d = rcnt_q - RCNT_W'(1);
                end
              end
            end
            default: begin
              state_d = R_IDLE;
              rcnt_d  = '0;
            end
          endcase
        end
      end

      // Repeat FSM state and countdown registers.
      always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
          state_q <= R_IDLE;
          rcnt_q  <= '0;
        end else begin
          state_q <= state_d;
          rcnt_q  <= rcnt_d;
        end
      end

      assign level_nxt_v[i] = level_d;
      assign btn_level[i]   = level_p2;
      assign btn_press[i]   = press_p2;
      assign btn_release[i] = rel_p2;
      assign btn_event[i]   = evt_p2;
    end
  endgenerate

  // any_level tracks the OR of the levels in the same cycle they update.
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      any_level <= 1'b0;
    end else begin
      any_level <= |level_nxt_v;
    end
  end

endmodule

// File: tb/tb_button_conditioner.sv
// Testbench for button_conditioner: scenario tasks compared against a
// window/timestamp-based reference model of the debounce and repeat rules.
module tb_button_conditioner;

  localparam int         N    = 2;
  localparam int         DC   = 4;
  localparam int         RD   = 10;
  localparam int         RP   = 3;
  localparam logic [1:0] MASK = 2'b01;

  logic         CLK;
  logic         reset;
  logic [N-1:0] btn_raw;
  logic [N-1:0] btn_level;
  logic [N-1:0] btn_press;
  logic [N-1:0] btn_release;
  logic [N-1:0] btn_event;
  logic         any_level;

  int checks;
  int errors;

  // Reference model state: edge count since reset release, raw sample history,
  // per-channel level, edge of last level change, edge of last press.
  int         t;
  logic [1:0] hist [0:8191];
  logic [1:0] mlevel;
  int         last_toggle [0:1];
  int         press_t [0:1];
  logic [1:0] mask_v;
  logic [1:0] e_level, e_press, e_rel, e_evt;
  logic       e_any;

  button_conditioner #(
    .N_BTN(N),
    .DEBOUNCE_CYCLES(DC),
    .REPEAT_DELAY(RD),
    .REPEAT_PERIOD(RP),
    .REPEAT_MASK(MASK)
  ) dut (
    .CLK(CLK),
    .reset(reset),
    .btn_raw(btn_raw),
    .btn_level(btn_level),
    .btn_press(btn_press),
    .btn_release(btn_release),
    .btn_event(btn_event),
    .any_level(any_level)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Synchronised value seen by the debouncer at edge e: raw sampled two edges earlier.
  function automatic logic sync_at(input int e, input int ch);
    logic [1:0] h;
    if (e >= 3) begin
      h = hist[e-2];
      return h[ch];
    end
    return 1'b0;
  endfunction

  task automatic model_reset();
    t = 0;
    mlevel = 2'b00;
    for (int ch = 0; ch < N; ch++) begin
      last_toggle[ch] = 0;
      press_t[ch] = -1;
    end
    e_level = '0; e_press = '0; e_rel = '0; e_evt = '0; e_any = 1'b0;
  endtask

  // Drive raw, take one clock edge, advance the model, then settle 1 time unit.
  task automatic step(input logic [1:0] raw);
    logic tog;
    btn_raw = raw;
    @(posedge CLK);
    t = t + 1;
    hist[t] = raw;
    e_press = '0;
    e_rel = '0;
    e_evt = '0;
    for (int ch = 0; ch < N; ch++) begin
      // Level flips when the last DC synchronised samples all disagree with it
      // and all of them were taken after the previous flip.
      tog = ((t - last_toggle[ch]) >= DC);
      for (int k = 0; k < DC; k++)
        if (sync_at(t - k, ch) == mlevel[ch]) tog = 1'b0;
      if (tog) begin
        if (mlevel[ch]) begin
          e_rel[ch] = 1'b1;
          press_t[ch] = -1;
        end else begin
          e_press[ch] = 1'b1;
          press_t[ch] = t;
        end
        mlevel[ch] = ~mlevel[ch];
        last_toggle[ch] = t;
      end
      e_evt[ch] = e_press[ch] |
                  (mask_v[ch] && mlevel[ch] && (press_t[ch] >= 0) &&
                   ((t - press_t[ch]) >= RD) && (((t - press_t[ch] - RD) % RP) == 0));
      e_level[ch] = mlevel[ch];
    end
    e_any = |e_level;
    #1;
  endtask

  task automatic apply_reset();
    reset = 1'b0;
    model_reset();
    repeat (2) @(posedge CLK);
    #1;
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    btn_raw = 2'b11;
    model_reset();
    for (int i = 0; i < 3; i++) begin
      @(posedge CLK);
      #1;
      if ({btn_level, btn_press, btn_release, btn_event, any_level} !== 9'b0) begin
        errors++;
        $display("FAIL reset_outputs cycle=%0d got %b expected %b", i,
                 {btn_level, btn_press, btn_release, btn_event, any_level}, 9'b0);
      end
      checks++;
    end
    #1;
    reset = 1'b1;
  endtask

  task automatic test_clean_press();
    apply_reset();
    for (int i = 0; i < 10; i++) begin
      step(2'b01);
      if ({btn_level, btn_press, btn_release, btn_event, any_level} !==
          {e_level, e_press, e_rel, e_evt, e_any}) begin
        errors++;
        $display("FAIL clean_press_model t=%0d got %b expected %b", t,
                 {btn_level, btn_press, btn_release, btn_event, any_level},
                 {e_level, e_press, e_rel, e_evt, e_any});
      end
      checks++;
      if ({btn_press[0], btn_event[0], btn_level[0], any_level} !==
          {(t == 6), (t == 6), (t >= 6), (t >= 6)}) begin
        errors++;
        $display("FAIL clean_press_timeline t=%0d got %b expected %b", t,
                 {btn_press[0], btn_event[0], btn_level[0], any_level},
                 {(t == 6), (t == 6), (t >= 6), (t >= 6)});
      end
      checks++;
    end
  endtask

  task automatic test_bounce();
    logic [9:0] pat;
    int presses;
    pat = 10'b1111110111;
    presses = 0;
    apply_reset();
    for (int i = 0; i < 16; i++) begin
      step({(i < 10) ? pat[i] : 1'b1, 1'b0});
      if (btn_press[1]) presses++;
      if ({btn_level, btn_press, btn_release, btn_event, any_level} !==
          {e_level, e_press, e_rel, e_evt, e_any}) begin
        errors++;
        $display("FAIL bounce_model t=%0d got %b expected %b", t,
                 {btn_level, btn_press, btn_release, btn_event, any_level},
                 {e_level, e_press, e_rel, e_evt, e_any});
      end
      checks++;
      if (btn_press[1] !== (t == 10)) begin
        errors++;
        $display("FAIL bounce_press_edge t=%0d got %b expected %b", t, btn_press[1], (t == 10));
      end
      checks++;
    end
    if (presses !== 1) begin
      errors++;
      $display("FAIL bounce_press_count got %0d expected 1", presses);
    end
    checks++;
  endtask

  task automatic test_auto_repeat_release();
    logic [2:0] exp_v;
    apply_reset();
    for (int i = 1; i <= 40; i++) begin
      step((i <= 17) ? 2'b11 : 2'b00);
      if ({btn_level, btn_press, btn_release, btn_event, any_level} !==
          {e_level, e_press, e_rel, e_evt, e_any}) begin
        errors++;
        $display("FAIL repeat_model t=%0d got %b expected %b", t,
                 {btn_level, btn_press, btn_release, btn_event, any_level},
                 {e_level, e_press, e_rel, e_evt, e_any});
      end
      checks++;
      exp_v = {(t == 6), (t == 6 || t == 16 || t == 19 || t == 22), (t == 23)};
      if ({btn_event, btn_release[0]} !== exp_v) begin
        errors++;
        $display("FAIL repeat_timeline t=%0d got %b expected %b", t,
                 {btn_event, btn_release[0]}, exp_v);
      end
      checks++;
    end
  endtask

  task automatic test_reset_mid_hold();
    apply_reset();
    for (int i = 0; i < 12; i++) begin
      step(2'b01);
      if ({btn_level, btn_press, btn_release, btn_event, any_level} !==
          {e_level, e_press, e_rel, e_evt, e_any}) begin
        errors++;
        $display("FAIL midreset_pre t=%0d got %b expected %b", t,
                 {btn_level, btn_press, btn_release, btn_event, any_level},
                 {e_level, e_press, e_rel, e_evt, e_any});
      end
      checks++;
    end
    reset = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      if ({btn_level, btn_press, btn_release, btn_event, any_level} !== 9'b0) begin
        errors++;
        $display("FAIL midreset_outputs_zero phase=%0d got %b expected %b", i,
                 {btn_level, btn_press, btn_release, btn_event, any_level}, 9'b0);
      end
      checks++;
      if (i < 2) begin
        @(posedge CLK);
        #1;
      end
    end
    reset = 1'b1;
    model_reset();
    for (int i = 0; i < 10; i++) begin
      step(2'b01);
      if ({btn_level, btn_press, btn_release, btn_event, any_level} !==
          {e_level, e_press, e_rel, e_evt, e_any}) begin
        errors++;
        $display("FAIL midreset_post t=%0d got %b expected %b", t,
                 {btn_level, btn_press, btn_release, btn_event, any_level},
                 {e_level, e_press, e_rel, e_evt, e_any});
      end
      checks++;
      if ({btn_press[0], btn_release[0]} !== {(t == 6), 1'b0}) begin
        errors++;
        $display("FAIL midreset_repress t=%0d got %b expected %b", t,
                 {btn_press[0], btn_release[0]}, {(t == 6), 1'b0});
      end
      checks++;
    end
  endtask

  task automatic test_simultaneous();
    apply_reset();
    for (int i = 0; i < 8; i++) begin
      step(2'b11);
      if (btn_press !== ((t == 6) ? 2'b11 : 2'b00)) begin
        errors++;
        $display("FAIL simultaneous_press t=%0d got %b expected %b", t,
                 btn_press, (t == 6) ? 2'b11 : 2'b00);
      end
      checks++;
    end
  endtask

  task automatic test_random();
    logic [1:0] r;
    int ovl;
    r = 2'b00;
    apply_reset();
    for (int i = 0; i < 900; i++) begin
      if ($urandom_range(0, 9) == 0) r[0] = ~r[0];
      if ($urandom_range(0, 9) == 0) r[1] = ~r[1];
      step(r);
      ovl = 0;
      for (int ch = 0; ch < N; ch++)
        if (btn_press[ch] && btn_release[ch]) ovl++;
      if ({btn_level, btn_press, btn_release, btn_event, any_level} !==
          {e_level, e_press, e_rel, e_evt, e_any}) begin
        errors++;
        $display("FAIL random_model t=%0d raw=%b got %b expected %b", t, r,
                 {btn_level, btn_press, btn_release, btn_event, any_level},
                 {e_level, e_press, e_rel, e_evt, e_any});
      end
      checks++;
      if (ovl !== 0) begin
        errors++;
        $display("FAIL random_press_release_overlap t=%0d got %0d expected 0", t, ovl);
      end
      checks++;
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    mask_v = MASK;
    reset = 1'b0;
    btn_raw = '0;
    model_reset();
    test_reset();
    test_clean_press();
    test_bounce();
    test_auto_repeat_release();
    test_reset_mid_hold();
    test_simultaneous();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
